// File: rtl/a51_pkg.sv
// Shared constants and types for the A5/1 keystream generator.
package a51_pkg;

    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    // Feedback tap masks: R1 {13,16,17,18}, R2 {20,21}, R3 {7,20,21,22}
    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

    // Majority clocking bit of each register
    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    // Phase lengths in cycles
    localparam int KEY_CYC   = 64;
    localparam int FRAME_CYC = 22;
    localparam int MIX_CYC   = 100;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_KEY   = 3'd1,
        LOAD_FRAME = 3'd2,
        MIX        = 3'd3,
        RUN        = 3'd4
    } state_t;

    // Complete LFSR state passed between step stages
    typedef struct packed {
        logic [R3_LEN-1:0] r3;
        logic [R2_LEN-1:0] r2;
        logic [R1_LEN-1:0] r1;
    } regs_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a51_step.sv
// One step of all three LFSRs: majority-clocked, or forced (every register
// steps, in_bit is XORed into the feedback) while loading key/frame bits.
module a51_step
    import a51_pkg::*;
(
    input  regs_t cur,
    input  logic  load,
    input  logic  in_bit,
    output regs_t nxt,
    output logic  z
);

    logic maj, s1, s2, s3, fb1, fb2, fb3;

    // Decide which registers step, shift them, and form the output bit
    always_comb begin
        maj = maj3(cur.r1[R1_CLK], cur.r2[R2_CLK], cur.r3[R3_CLK]);
        s1  = load | (cur.r1[R1_CLK] == maj);
        s2  = load | (cur.r2[R2_CLK] == maj);
        s3  = load | (cur.r3[R3_CLK] == maj);
        fb1 = (^(cur.r1 & R1_TAPS)) ^ (load & in_bit);
        fb2 = (^(cur.r2 & R2_TAPS)) ^ (load & in_bit);
        fb3 = (^(cur.r3 & R3_TAPS)) ^ (load & in_bit);
        nxt = cur;
        if (s1) nxt.r1 = {cur.r1[R1_LEN-2:0], fb1};
        if (s2) nxt.r2 = {cur.r2[R2_LEN-2:0], fb2};
        if (s3) nxt.r3 = {cur.r3[R3_LEN-2:0], fb3};
        z = nxt.r1[R1_LEN-1] ^ nxt.r2[R2_LEN-1] ^ nxt.r3[R3_LEN-1];
    end

endmodule

// File: rtl/a51_keygen.sv
// A5/1 keystream generator: loads key and frame number, mixes 100 cycles,
// then streams KS_BITS keystream bits as OUT_W-bit words over valid/ready.
module a51_keygen
    import a51_pkg::*;
#(
    parameter int OUT_W   = 1,
    parameter int KS_BITS = 228
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [63:0]       key,
    input  logic [21:0]       frame,
    output logic              busy,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic [OUT_W-1:0]  ks_data,
    output logic              ks_last,
    output logic [18:0]       out19,
    output logic [21:0]       out22,
    output logic [22:0]       out23
);

    localparam int WORDS   = KS_BITS / OUT_W;
    localparam int CNT_MAX = (WORDS > MIX_CYC) ? WORDS : MIX_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state, state_nx;
    regs_t              regs;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        key_q;
    logic [21:0]        frame_q;
    logic [31:0]        frame_ext;
    logic               load_bit, loading, phase_end, word_load;
    regs_t              step_nxt;
    logic               step_z_unused;
    regs_t              run_nxt;
    logic [OUT_W-1:0]   zbits;

    assign busy      = (state != IDLE);
    assign out19     = regs.r1;
    assign out22     = regs.r2;
    assign out23     = regs.r3;
    assign frame_ext = {10'b0, frame_q};
    assign loading   = (state == LOAD_KEY) || (state == LOAD_FRAME);
    assign load_bit  = (state == LOAD_KEY) ? key_q[cnt[5:0]] : frame_ext[cnt[4:0]];

    // Single step used during key/frame load (forced) and mixing (majority)
    a51_step u_step (
        .cur    (regs),
        .load   (loading),
        .in_bit (load_bit),
        .nxt    (step_nxt),
        .z      (step_z_unused)
    );

    // OUT_W majority steps chained so a whole word is produced per cycle
    for (genvar g = 0; g < OUT_W; g++) begin : g_run
        regs_t cin, cout;
        logic  zb;
        if (g == 0) begin : g_first
            assign cin = regs;
        end else begin : g_next
            assign cin = g_run[g-1].cout;
        end
        a51_step u_step (
            .cur    (cin),
            .load   (1'b0),
            .in_bit (1'b0),
            .nxt    (cout),
            .z      (zb)
        );
        assign zbits[g] = zb;
    end
    assign run_nxt = g_run[OUT_W-1].cout;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state, phase boundaries and word-load enable
    always_comb begin
        state_nx  = state;
        phase_end = 1'b0;
        word_load = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD_KEY;
            end
            LOAD_KEY: begin
                phase_end = (cnt == CNT_W'(KEY_CYC - 1));
                if (phase_end) state_nx = LOAD_FRAME;
            end
            LOAD_FRAME: begin
                phase_end = (cnt == CNT_W'(FRAME_CYC - 1));
                if (phase_end) state_nx = MIX;
            end
            MIX: begin
                phase_end = (cnt == CNT_W'(MIX_CYC - 1));
                if (phase_end) state_nx = RUN;
            end
            RUN: begin
                // after the last word is loaded only its handshake remains
                word_load = (!ks_valid || ks_ready) && !ks_last;
                if (ks_valid && ks_ready && ks_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: captured inputs, LFSRs, phase/word counter, output word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs     <= '0;
            cnt      <= '0;
            key_q    <= '0;
            frame_q  <= '0;
            ks_valid <= 1'b0;
            ks_data  <= '0;
            ks_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        key_q   <= key;
                        frame_q <= frame;
                        regs    <= '0;
                        cnt     <= '0;
                    end
                end
                LOAD_KEY, LOAD_FRAME, MIX: begin
                    regs <= step_nxt;
                    cnt  <= phase_end ? '0 : cnt + CNT_W'(1);
                end
                RUN: begin
                    if (word_load) begin
                        regs     <= run_nxt;
                        ks_data  <= zbits;
                        ks_valid <= 1'b1;
                        ks_last  <= (cnt == CNT_W'(WORDS - 1));
                        cnt      <= cnt + CNT_W'(1);
                    end else if (ks_valid && ks_ready) begin
                        ks_valid <= 1'b0;
                        ks_last  <= 1'b0;
                        cnt      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_a51_keygen.sv
// Scoreboard bench: two generators (1-bit and 4-bit words) share stimulus;
// expected words are pushed when a start is accepted, monitors pop/compare.
module tb_a51_keygen;

    localparam logic [63:0] VKEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0] VFRAME = 22'h134;

    logic        clock = 1'b0;
    logic        reset, start, rdy1, rdy4;
    logic [63:0] key;
    logic [21:0] frame;

    logic        busy1, v1, last1;
    logic [0:0]  d1;
    logic [18:0] o19_1;
    logic [21:0] o22_1;
    logic [22:0] o23_1;
    logic        busy4, v4, last4;
    logic [3:0]  d4;
    logic [18:0] o19_4;
    logic [21:0] o22_4;
    logic [22:0] o23_4;

    a51_keygen #(.OUT_W(1), .KS_BITS(228)) dut1 (
        .clock(clock), .reset(reset), .start(start), .key(key), .frame(frame),
        .busy(busy1), .ks_valid(v1), .ks_ready(rdy1), .ks_data(d1), .ks_last(last1),
        .out19(o19_1), .out22(o22_1), .out23(o23_1));

    a51_keygen #(.OUT_W(4), .KS_BITS(228)) dut4 (
        .clock(clock), .reset(reset), .start(start), .key(key), .frame(frame),
        .busy(busy4), .ks_valid(v4), .ks_ready(rdy4), .ks_data(d4), .ks_last(last4),
        .out19(o19_4), .out22(o22_4), .out23(o23_4));

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference A5/1: 86 forced load clocks, 100 majority clocks discarded,
    // then 228 majority clocks each yielding one keystream bit.
    function automatic logic [227:0] model_ks(input logic [63:0] k, input logic [21:0] f);
        logic [31:0]  r   [3];
        logic [31:0]  tap [3];
        int           len [3];
        int           cb  [3];
        logic [85:0]  ld;
        logic [227:0] ks;
        int           ones;
        logic         maj;
        tap = '{32'h0007_2000, 32'h0030_0000, 32'h0070_0080};
        len = '{19, 22, 23};
        cb  = '{8, 10, 10};
        ld  = {f, k};
        ks  = '0;
        for (int j = 0; j < 3; j++) r[j] = '0;
        for (int i = 0; i < 86; i++)
            for (int j = 0; j < 3; j++)
                r[j] = ((r[j] << 1) | 32'((^(r[j] & tap[j])) ^ ld[i])) & ((32'd1 << len[j]) - 1);
        for (int i = 0; i < 328; i++) begin
            ones = 0;
            for (int j = 0; j < 3; j++) ones += int'(r[j][cb[j]]);
            maj = (ones >= 2);
            for (int j = 0; j < 3; j++)
                if (r[j][cb[j]] == maj)
                    r[j] = ((r[j] << 1) | 32'(^(r[j] & tap[j]))) & ((32'd1 << len[j]) - 1);
            if (i >= 100) ks[i-100] = r[0][18] ^ r[1][21] ^ r[2][22];
        end
        return ks;
    endfunction

    logic [3:0] q1_d[$], q4_d[$];
    bit         q1_l[$], q4_l[$];
    int         wc1 = 0, wc4 = 0, e0_1 = 0, e0_4 = 0;
    bit         await1 = 0, await4 = 0, done1 = 0, done4 = 0;
    bit         cap_en = 0, cap4_en = 0;
    int         cap_n = 0;
    logic [23:0] cap1 = '0;
    logic [3:0]  first4 = '0;

    // Monitor / scoreboard for the 1-bit generator
    always @(negedge clock) begin
        logic [227:0] ks;
        if (reset) begin
            q1_d.delete(); q1_l.delete();
            wc1 = 0; await1 = 0; done1 = 0;
        end else begin
            if (done1) begin
                chk("idle_after_last1", {busy1, v1}, 2'b00);
                done1 = 0;
            end
            if (v1 && await1) begin
                chk("latency1", cyc, e0_1 + 187);
                await1 = 0;
            end
            if (v1 && rdy1) begin
                if (q1_d.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_word1: got %0h expected none", d1);
                end else begin
                    chk("data1", d1, q1_d.pop_front());
                    chk("last1", last1, q1_l.pop_front());
                    wc1++;
                    if (cap_en && cap_n < 24) begin cap1[cap_n] = d1[0]; cap_n++; end
                    if (last1) begin chk("words1", wc1, 228); wc1 = 0; done1 = 1; end
                end
            end
            if (start && !busy1) begin
                ks = model_ks(key, frame);
                for (int i = 0; i < 228; i++) begin
                    q1_d.push_back({3'b000, ks[i]});
                    q1_l.push_back(i == 227);
                end
                await1 = 1; e0_1 = cyc + 1;
            end
        end
    end

    // Monitor / scoreboard for the 4-bit generator
    always @(negedge clock) begin
        logic [227:0] ks;
        if (reset) begin
            q4_d.delete(); q4_l.delete();
            wc4 = 0; await4 = 0; done4 = 0;
        end else begin
            if (done4) begin
                chk("idle_after_last4", {busy4, v4}, 2'b00);
                done4 = 0;
            end
            if (v4 && await4) begin
                chk("latency4", cyc, e0_4 + 187);
                await4 = 0;
            end
            if (v4 && rdy4) begin
                if (q4_d.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_word4: got %0h expected none", d4);
                end else begin
                    chk("data4", d4, q4_d.pop_front());
                    chk("last4", last4, q4_l.pop_front());
                    wc4++;
                    if (cap4_en) begin first4 = d4; cap4_en = 0; end
                    if (last4) begin chk("words4", wc4, 57); wc4 = 0; done4 = 1; end
                end
            end
            if (start && !busy4) begin
                ks = model_ks(key, frame);
                for (int w = 0; w < 57; w++) begin
                    q4_d.push_back(ks[4*w +: 4]);
                    q4_l.push_back(w == 56);
                end
                await4 = 1; e0_4 = cyc + 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy1 || busy4) && n < budget) begin step(1); n++; end
        if (busy1 || busy4) begin
            tests++; fails++;
            $display("FAIL idle_timeout: got busy %b%b expected 00", busy1, busy4);
        end
        step(2);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl1"}, {busy1, v1, d1, last1}, '0);
        chk({name, "_regs1"}, {o19_1, o22_1, o23_1}, '0);
        chk({name, "_ctl4"}, {busy4, v4, d4, last4}, '0);
        chk({name, "_regs4"}, {o19_4, o22_4, o23_4}, '0);
    endtask

    initial begin
        logic [7:0]  byt;
        logic [18:0] s19;
        logic [21:0] s22;
        logic [22:0] s23;
        logic        sd;
        int          n;

        reset = 1'b1; start = 1'b0; rdy1 = 1'b1; rdy4 = 1'b1;
        key = VKEY; frame = VFRAME;
        step(3);
        chk_zero("reset");
        reset = 1'b0;
        step(2);

        // Reference vector, full throughput
        cap_en = 1; cap4_en = 1; cap_n = 0;
        pulse_start();
        wait_idle(600);
        cap_en = 0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) byt[7-i] = cap1[8*b+i];
            case (b)
                0: chk("vec_byte0", byt, 8'h53);
                1: chk("vec_byte1", byt, 8'h4E);
                default: chk("vec_byte2", byt, 8'hAA);
            endcase
        end
        chk("vec_first4", first4, 4'b1010);

        // Start with a different key mid-frame must be ignored
        pulse_start();
        step(49);
        key = 64'h0123_4567_89AB_CDEF; start = 1'b1;
        step(1);
        start = 1'b0; key = VKEY;
        wait_idle(600);

        // Backpressure on the 1-bit stream for 20 cycles after first valid
        rdy1 = 1'b0;
        pulse_start();
        n = 0;
        while (!v1 && n < 300) begin step(1); n++; end
        chk("bp_valid", v1, 1'b1);
        sd = d1[0]; s19 = o19_1; s22 = o22_1; s23 = o23_1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("bp_hold", {v1, d1, o19_1, o22_1, o23_1}, {1'b1, sd, s19, s22, s23});
        end
        rdy1 = 1'b1;
        wait_idle(600);

        // Reset during MIX abandons the frame; a new start is required
        pulse_start();
        step(119);
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        step(2);
        reset = 1'b0;
        step(3);
        chk("no_autostart", {busy1, busy4}, 2'b00);
        pulse_start();
        wait_idle(600);

        // Back-to-back frames with start held high
        start = 1'b1;
        step(420);
        start = 1'b0;
        wait_idle(900);

        // Random keys/frames with random backpressure
        for (int f = 0; f < 3; f++) begin
            key = {$urandom, $urandom};
            frame = 22'($urandom);
            pulse_start();
            n = 0;
            while ((busy1 || busy4) && n < 2000) begin
                rdy1 = 1'($urandom_range(0, 1));
                rdy4 = 1'($urandom_range(0, 1));
                step(1); n++;
            end
            rdy1 = 1'b1; rdy4 = 1'b1;
            wait_idle(50);
        end

        chk("q1_drained", q1_d.size(), 0);
        chk("q4_drained", q4_d.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/a51_keygen.md
A51_KEYGEN -- requirements
Module: a51_keygen

Interface
REQ-001 SHALL have parameter OUT_W, default 1, keystream bits per output word; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter KS_BITS, default 228, keystream bits per frame; must be a multiple of OUT_W.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begins a frame when sampled high in IDLE.
REQ-006 SHALL have port key, input, 64, session key; bit i is the i-th bit loaded.
REQ-007 SHALL have port frame, input, 22, frame number; bit i is the i-th bit loaded.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port ks_valid, output, 1, ks_data holds a valid word.
REQ-010 SHALL have port ks_ready, input, 1, consumer accepts the word when ks_valid and ks_ready are both high.
REQ-011 SHALL have port ks_data, output, OUT_W, keystream word; bit 0 is the earliest generated bit.
REQ-012 SHALL have port ks_last, output, 1, marks the final word of the frame.
REQ-013 SHALL have ports out19, out22 and out23, outputs, 19, 22 and 23 bits, live contents of R1, R2 and R3 (debug).

Function
REQ-014 SHALL implement R1 with feedback taps 13,16,17,18 and clock bit 8; R2 with taps 20,21 and clock bit 10; R3 with taps 7,20,21,22 and clock bit 10.
REQ-015 SHALL define one register step as R <= {R[n-2:0], fb}, where fb is the XOR of the register's taps.
REQ-016 SHALL use the FSM states IDLE -> LOAD_KEY -> LOAD_FRAME -> MIX -> RUN -> IDLE.
REQ-017 SHALL, in IDLE on start=1 (edge E0), capture key and frame internally, zero R1, R2 and R3, and enter LOAD_KEY.
REQ-018 SHALL, in LOAD_KEY (64 cycles, edges E1..E64), step all three registers every cycle, with fb XOR key[i] as the shifted-in bit.
REQ-019 SHALL, in LOAD_FRAME (22 cycles, edges E65..E86), behave as LOAD_KEY but use frame[i].
REQ-020 SHALL, in MIX (100 cycles, edges E87..E186), clock with majority and discard the output.
REQ-021 SHALL apply majority clocking as follows: maj = majority of the three clock bits; a register steps only when its clock bit equals maj.
REQ-022 SHALL, in RUN, compute each keystream bit as R1[18]^R2[21]^R3[22], taken after that bit's majority step.
REQ-023 SHALL, in RUN, load the output word when ks_valid=0 or ks_ready=1; each load performs OUT_W unrolled majority steps in one cycle.
REQ-024 SHALL register the first word at E187, so that ks_valid is high after E187.
REQ-025 SHALL, when ks_valid=1 and ks_ready=0, freeze ks_data, ks_last and R1/R2/R3 (stall).
REQ-026 SHALL assert ks_last with word KS_BITS/OUT_W; when that word is accepted, ks_valid drops, the FSM returns to IDLE and busy falls on the same edge.
REQ-027 SHALL ignore start while busy=1, and SHALL NOT re-sample key or frame mid-frame.
REQ-028 SHALL accept start in the cycle immediately after the last-word handshake.
REQ-029 SHALL keep all counters wide enough for max(100, KS_BITS/OUT_W), with no wrap within a frame.

Reset
REQ-030 SHALL, on reset=1, asynchronously set state=IDLE, R1=R2=R3=0, all counters 0, busy=0, ks_valid=0, ks_data=0 and ks_last=0.
REQ-031 SHALL, on reset asserted mid-frame, abandon the frame with no further valid words.
REQ-032 SHALL, after reset deasserts, require a new start.

Structure
REQ-033 SHALL place register lengths, tap positions, clock-bit positions, phase lengths (64, 22, 100) and the FSM state encoding in shared package a51_pkg.
REQ-034 SHALL implement a single sub-module a51_step (combinational; one majority or forced step of all three registers, returning the next registers and the output bit), instantiated OUT_W times in a chain for RUN and once for load/mix.

Verification
REQ-035 SHALL cover the vector: OUT_W=1, key=64'hEFCDAB8967452312, frame=22'h134, ks_ready=1 -> first 8 bits in time order 0,1,0,1,0,0,1,1 (0x53 MSB-first), next bytes 0x4E and 0xAA; 228 words; ks_last on word 228; busy low after it.
REQ-036 SHALL cover the same vector with OUT_W=4 -> first ks_data=4'b1010 (bit0=0, bit1=1, bit2=0, bit3=1); 57 words; ks_valid first high after E187.
REQ-037 SHALL cover backpressure: ks_ready held 0 for 20 cycles after the first valid -> ks_data, out19, out22 and out23 stable; the stream after release is identical to REQ-035.
REQ-038 SHALL cover start pulsed at E50 with a different key -> ignored; output identical to REQ-035.
REQ-039 SHALL cover reset asserted during MIX (E120) -> all outputs 0 immediately; a fresh start then reproduces REQ-035.
REQ-040 SHALL cover back-to-back frames, with start held high continuously -> the second frame begins on the edge after the last-word handshake, with correct latency of 187 edges.
